// File: rtl/ct_spsram_pkg.sv
// Shared definitions for the parametrised single-port SRAM wrapper:
// init-FSM state encoding and bank-geometry helpers.
package ct_spsram_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    function automatic int unsigned wrap_size(input int unsigned data_width,
                                              input int unsigned banks);
        return data_width / banks;
    endfunction

    function automatic bit wrap_ok(input int unsigned data_width,
                                   input int unsigned banks);
        return (data_width % banks) == 0;
    endfunction

endpackage

// File: rtl/my_fpga_ram.sv
// One write bank of the SRAM wrapper: synchronous single-port array,
// registered read-out, read-before-write on a same-address write.
module my_fpga_ram #(
    parameter int unsigned WRAP_SIZE  = 23,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wen,
    input  logic [WRAP_SIZE-1:0]  din,
    output logic [WRAP_SIZE-1:0]  dout
);

    logic [WRAP_SIZE-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/ct_f_spsram_param_init.sv
// Parametrised single-port SRAM wrapper: banked active-low writes, write-first
// read-out, optional output register and a hardware init sweep.
module ct_f_spsram_param_init
    import ct_spsram_pkg::*;
#(
    parameter int unsigned                 ADDR_WIDTH    = 10,
    parameter int unsigned                 DATA_WIDTH    = 92,
    parameter int unsigned                 BANKS         = 4,
    parameter int unsigned                 OUT_REG       = 0,
    parameter int unsigned                 INIT_ON_RESET = 1,
    parameter logic [DATA_WIDTH/BANKS-1:0] INIT_VALUE    = '0
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    input  logic                  INIT_REQ,
    output logic                  INIT_BUSY
);

    localparam int unsigned WRAP_SIZE = wrap_size(DATA_WIDTH, BANKS);

    if (!wrap_ok(DATA_WIDTH, BANKS)) begin : g_bad_cfg
        $error("DATA_WIDTH must be a multiple of BANKS");
    end

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] addr_holding;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  idle;
    logic                  init_q;
    logic [BANKS-1:0]      user_wen;
    logic [BANKS-1:0]      wen_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] q_next;
    logic                  q_blank;
    logic                  unused_wen;

    // Only the top bit of each WRAP_SIZE slice qualifies its bank.
    assign unused_wen = ^WEN;

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (INIT_REQ)  state_next = ST_INIT;
            ST_INIT: if (&init_cnt) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        INIT_BUSY = (state == ST_INIT);
    end

    assign idle = (state == ST_IDLE);

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            init_cnt     <= '0;
            addr_holding <= '0;
        end else if (INIT_BUSY) begin
            init_cnt <= init_cnt + 1'b1;
            if (&init_cnt) begin
                addr_holding <= '0;
            end
        end else if (!CEN) begin
            addr_holding <= A;
        end
    end

    assign ram_addr = INIT_BUSY ? init_cnt : (CEN ? addr_holding : A);

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wen_q  <= '0;
            din_q  <= '0;
            init_q <= 1'b0;
        end else begin
            wen_q  <= user_wen;
            din_q  <= D;
            init_q <= INIT_BUSY;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        localparam int unsigned LO = b * WRAP_SIZE;
        logic [WRAP_SIZE-1:0] dout;

        assign user_wen[b] = idle && !CEN && !GWEN && !WEN[LO+WRAP_SIZE-1];

        my_fpga_ram #(
            .WRAP_SIZE (WRAP_SIZE),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clk (CLK),
            .addr(ram_addr),
            .wen (INIT_BUSY || user_wen[b]),
            .din (INIT_BUSY ? INIT_VALUE : D[LO +: WRAP_SIZE]),
            .dout(dout)
        );

        // Registered bypass makes write-first independent of the primitive.
        assign rd_data[LO +: WRAP_SIZE] = wen_q[b] ? din_q[LO +: WRAP_SIZE] : dout;
    end

    // The first cycle after a sweep still shows the pre-clear word at DEPTH-1.
    assign q_blank = INIT_BUSY || init_q;
    assign q_next  = q_blank ? '0 : rd_data;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_reg;

        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                q_reg <= '0;
            end else begin
                q_reg <= q_next;
            end
        end

        assign Q = q_blank ? '0 : q_reg;
    end else begin : g_no_out_reg
        assign Q = q_next;
    end

endmodule
